load_store_unit: RTL

//  Data-memory stage for the rv32i multicycle core: executes LB/LH/LW/LBU/LHU/SB/SH/SW handed over by EXEC.

---
 rtl/load_store_unit_pkg.sv | 18 +
 rtl/load_store_unit_if.sv | 35 +++
 rtl/load_store_unit_lane_align.sv | 25 ++
 rtl/load_store_unit.sv | 101 ++++++++++
 4 files changed

// File: rtl/load_store_unit_pkg.sv
// load_store_unit_pkg: shared rv32i load/store encodings, LSU states and fault causes
package load_store_unit_pkg;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;
    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} lsu_state_e;
    typedef enum logic [2:0] {F_NONE, F_FUNCT3, F_MISALIGN, F_RANGE, F_TIMEOUT} fault_e;
    function automatic logic bad_funct3(input logic is_store, input logic [2:0] funct3);
        return is_store ? funct3 >= 3'b011 : (funct3 == 3'b011 || funct3[2:1] == 2'b11);
    endfunction
endpackage

// File: rtl/load_store_unit_if.sv
// load_store_unit_if: core request/response and data-RAM bus of the LSU
interface load_store_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_is_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_base;
    logic [11:0] req_offset;
    logic [31:0] req_wdata;
    logic [4:0]  req_rd;
    logic        resp_valid;
    logic [4:0]  resp_rd;
    logic [31:0] resp_rdata;
    logic        resp_fault;
    logic [31:0] resp_fault_addr;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    modport slave (
        input  req_valid, req_is_store, req_funct3, req_base, req_offset, req_wdata, req_rd,
        input  mem_ack, mem_rdata,
        output req_ready, resp_valid, resp_rd, resp_rdata, resp_fault, resp_fault_addr,
        output mem_req, mem_we, mem_addr, mem_be, mem_wdata
    );
    modport master (
        output req_valid, req_is_store, req_funct3, req_base, req_offset, req_wdata, req_rd,
        output mem_ack, mem_rdata,
        input  req_ready, resp_valid, resp_rd, resp_rdata, resp_fault, resp_fault_addr,
        input  mem_req, mem_we, mem_addr, mem_be, mem_wdata
    );
endinterface

// File: rtl/load_store_unit_lane_align.sv
// load_store_unit_lane_align: byte enables, store replication, load extract/extend, misalign flag
module load_store_unit_lane_align (
    input  logic [1:0]  ea_lo,
    input  logic [2:0]  funct3,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata_rep,
    output logic [31:0] rdata_ext,
    output logic        misaligned
);
    logic [1:0]  size;
    logic [31:0] lane;
    logic        sgn;
    always_comb begin
        size       = funct3[1:0];
        lane       = rdata >> {ea_lo, 3'b000};
        sgn        = ~funct3[2];
        be         = size == 2'd0 ? 4'b0001 << ea_lo : size == 2'd1 ? 4'b0011 << ea_lo : 4'b1111;
        wdata_rep  = size == 2'd0 ? {4{wdata[7:0]}} : size == 2'd1 ? {2{wdata[15:0]}} : wdata;
        rdata_ext  = size == 2'd0 ? {{24{sgn & lane[7]}}, lane[7:0]} :
                     size == 2'd1 ? {{16{sgn & lane[15]}}, lane[15:0]} : lane;
        misaligned = (size == 2'd1 && ea_lo[0]) || (size == 2'd2 && ea_lo != 2'b00);
    end
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: rv32i data-memory stage with RAM req/ack handshake and one registered response per op
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int ADDR_LIMIT     = 4096
) (
    input logic               clk,
    input logic               rst,
    load_store_unit_if.slave  bus
);
    localparam int          TW    = TIMEOUT_CYCLES > 1 ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TMAX  = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [31:0] LIMIT = 32'(ADDR_LIMIT);
    lsu_state_e    state, state_d;
    fault_e        cause;
    logic          is_store_q;
    logic [2:0]    funct3_q;
    logic [31:0]   ea_q, wdata_q, ea_in;
    logic [4:0]    rd_q, r_rd;
    logic [31:0]   r_rdata, r_addr;
    logic          r_fault;
    logic [TW-1:0] cnt;
    logic          idle, access, tmo, mis;
    logic [3:0]    be;
    logic [31:0]   wdata_rep, rdata_ext;
    assign idle   = state == S_IDLE;
    assign access = state == S_ACCESS;
    assign ea_in  = bus.req_base + {{20{bus.req_offset[11]}}, bus.req_offset};
    assign tmo    = access && TIMEOUT_CYCLES != 0 && cnt == TMAX;
    // While idle the aligner screens the incoming request; afterwards it serves the latched op
    load_store_unit_lane_align align (
        .ea_lo      (idle ? ea_in[1:0] : ea_q[1:0]),
        .funct3     (idle ? bus.req_funct3 : funct3_q),
        .wdata      (wdata_q),
        .rdata      (bus.mem_rdata),
        .be         (be),
        .wdata_rep  (wdata_rep),
        .rdata_ext  (rdata_ext),
        .misaligned (mis)
    );
    always_comb begin
        cause = F_NONE;
        if (bad_funct3(bus.req_is_store, bus.req_funct3)) cause = F_FUNCT3;
        else if (mis) cause = F_MISALIGN;
        else if (ea_in >= LIMIT) cause = F_RANGE;
        state_d = state;
        if (idle && bus.req_valid) state_d = cause == F_NONE ? S_ACCESS : S_RESP;
        else if (access && (bus.mem_ack || tmo)) state_d = S_RESP;
        else if (state == S_RESP) state_d = S_IDLE;
    end
    always_ff @(posedge clk) state <= rst ? S_IDLE : state_d;
    always_ff @(posedge clk) begin
        if (rst) begin
            is_store_q <= 1'b0;
            funct3_q   <= '0;
            ea_q       <= '0;
            wdata_q    <= '0;
            rd_q       <= '0;
            cnt        <= '0;
            r_rd       <= '0;
            r_rdata    <= '0;
            r_fault    <= 1'b0;
            r_addr     <= '0;
        end else begin
            if (idle && bus.req_valid) begin
                is_store_q <= bus.req_is_store;
                funct3_q   <= bus.req_funct3;
                ea_q       <= ea_in;
                wdata_q    <= bus.req_wdata;
                rd_q       <= bus.req_rd;
                cnt        <= '0;
                r_rd       <= '0;
                r_rdata    <= '0;
                r_fault    <= cause != F_NONE;
                r_addr     <= cause != F_NONE ? ea_in : '0;
            end
            if (access) begin
                cnt <= cnt + 1'b1;
                if (bus.mem_ack) begin
                    r_rd    <= is_store_q ? 5'd0 : rd_q;
                    r_rdata <= is_store_q ? 32'd0 : rdata_ext;
                end else if (tmo) begin
                    r_fault <= 1'b1;
                    r_addr  <= ea_q;
                end
            end
        end
    end
    assign bus.req_ready       = idle;
    assign bus.resp_valid      = state == S_RESP;
    assign bus.resp_rd         = bus.resp_valid ? r_rd : '0;
    assign bus.resp_rdata      = bus.resp_valid ? r_rdata : '0;
    assign bus.resp_fault      = bus.resp_valid && r_fault;
    assign bus.resp_fault_addr = bus.resp_valid ? r_addr : '0;
    assign bus.mem_req         = access;
    assign bus.mem_we          = access && is_store_q;
    assign bus.mem_addr        = access ? {ea_q[31:2], 2'b00} : '0;
    assign bus.mem_be          = access ? be : '0;
    assign bus.mem_wdata       = access && is_store_q ? wdata_rep : '0;
endmodule
